wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Integer register file for the rv32 single-cycle core.
- Sits on the receiving end of the write-back interface: consumes the write-back enable, destination id and write data, and serves the two decode-stage source operand reads.
- Contains a post-reset clear sequencer that zeroes x1..x31 one entry per cycle, so the storage can map to FPGA RAM without a parallel reset.
- Provides a debug read port and a sticky flag for write-backs dropped during the clear sequence.

Parameters:
XLEN, 32, data width of each register
REG_NUM, 32, number of architectural registers including x0
ADDR_W, 5, register id width; must equal clog2(REG_NUM)
BYPASS, 1, 1 = same-cycle write-to-read forwarding on rs1/rs2; 0 = no forwarding

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
wb_rd_write_en_i  input  1  write-back register write enable
wb_rd_id_i  input  ADDR_W  write-back destination register id
wb_rd_write_data_i  input  XLEN  write-back data (load data or ALU result)
rs1_id_i  input  ADDR_W  source register 1 id
rs2_id_i  input  ADDR_W  source register 2 id
rs1_data_o  output  XLEN  source register 1 data, combinational
rs2_data_o  output  XLEN  source register 2 data, combinational
dbg_id_i  input  ADDR_W  debug read id
dbg_data_o  output  XLEN  debug read data, registered, 1-cycle latency
rf_ready_o  output  1  1 = clear sequence finished; register file is live
wb_drop_o  output  1  sticky; a write-back was discarded during the clear sequence

Behaviour:
- Reset is synchronous, active-high: clk and rst only; no asynchronous paths.
- FSM states: CLEAR, RUN.
- Reset:
  - In any cycle with rst=1, the next state is CLEAR, clr_cnt=1, rf_ready_o=0, wb_drop_o=0, dbg_data_o=0.
  - Register contents are not reset in parallel.
- CLEAR:
  - Each cycle, entry clr_cnt is written with 0 and clr_cnt increments.
  - When clr_cnt == REG_NUM-1, that entry is written, the state moves to RUN and rf_ready_o=1 from the next cycle.
  - After rst drops, CLEAR lasts exactly REG_NUM-1 = 31 cycles.
- CLEAR reads and write-backs:
  - rs1_data_o, rs2_data_o and dbg_data_o are forced to 0.
  - A write-back with wb_rd_write_en_i=1 and wb_rd_id_i != 0 is discarded and sets wb_drop_o=1 on the next edge.
  - wb_drop_o is cleared only by rst.
- RUN writes:
  - On the rising edge with wb_rd_write_en_i=1 and wb_rd_id_i != 0, entry wb_rd_id_i takes wb_rd_write_data_i.
  - Writes to x0 are ignored silently and never set wb_drop_o.
- RUN reads:
  - rsN_data_o is 0 when rsN_id_i == 0; otherwise it is the stored entry, asynchronous read.
  - With BYPASS=1, when wb_rd_write_en_i=1, wb_rd_id_i == rsN_id_i and the id != 0, rsN_data_o = wb_rd_write_data_i in the same cycle.
  - Both ports can forward simultaneously when rs1_id_i == rs2_id_i.
- Debug port: dbg_data_o <= (dbg_id_i==0) ? 0 : stored entry, sampled at the edge before any same-edge write, i.e. old data. Not affected by BYPASS.
- Reset during CLEAR or RUN: clr_cnt restarts at 1 and rf_ready_o falls at the next edge. Register contents are undefined until the new CLEAR completes.
- rf_ready_o is registered and never glitches.

Test Plan:
- Pulse rst for 1 cycle, then idle → rf_ready_o=0 for exactly 31 cycles, 1 on cycle 32. After that, reading rs1_id=1..31 returns 0x00000000 and wb_drop_o=0.
- After ready: write x5=0xDEADBEEF, then next cycle rs1_id=5, rs2_id=5 → both read 0xDEADBEEF. Write x0=0x12345678 → rs1_id=0 reads 0, wb_drop_o stays 0.
- BYPASS=1: in the same cycle write x7=0xA5A5A5A5 with rs1_id=7 while x7 holds 0x11111111 → rs1_data_o=0xA5A5A5A5 combinationally; dbg_id=7 gives dbg_data_o=0x11111111 next cycle. BYPASS=0: rs1_data_o=0x11111111.
- During CLEAR (cycle 10), write x3=0x55 → wb_drop_o=1 next cycle and stays 1. After ready, x3 reads 0.
- Fill all registers with their index in RUN, assert rst at an arbitrary RUN cycle → rf_ready_o=0 next edge, 31-cycle clear repeats, then all registers read 0.
- Back-to-back writes: x31=1, x31=2, x31=3 on consecutive cycles with rs2_id=31 → rs2_data_o tracks 1, 2, 3 each cycle with BYPASS=1 (lags one cycle with BYPASS=0); final stored value 3.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: rv32 integer register file fed by the write-back stage, with two
// asynchronous operand reads, a registered debug read and a post-reset zeroing sequencer.
module wb_regfile #(
   parameter int XLEN    = 32,
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5,
   parameter int BYPASS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_rd_write_en_i,
   input  logic [ADDR_W-1:0] wb_rd_id_i,
   input  logic [XLEN-1:0]   wb_rd_write_data_i,
   input  logic [ADDR_W-1:0] rs1_id_i,
   input  logic [ADDR_W-1:0] rs2_id_i,
   output logic [XLEN-1:0]   rs1_data_o,
   output logic [XLEN-1:0]   rs2_data_o,
   input  logic [ADDR_W-1:0] dbg_id_i,
   output logic [XLEN-1:0]   dbg_data_o,
   output logic              rf_ready_o,
   output logic              wb_drop_o
);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              rf_ready_q;
   logic              wb_drop_q;
   logic [XLEN-1:0]   dbg_data_q;
   logic [XLEN-1:0]   regs_q [REG_NUM];

   logic              wb_hit_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [XLEN-1:0]   mem_wdata_s;
   logic [XLEN-1:0]   rs1_data_s;
   logic [XLEN-1:0]   rs2_data_s;

   assign wb_hit_s = wb_rd_write_en_i && (wb_rd_id_i != '0);

   // Single write port: the clear sequencer owns it in CLEAR, write-back owns it in RUN.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = wb_rd_id_i;
      mem_wdata_s = wb_rd_write_data_i;
      if (rst) begin
         mem_we_s = 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               mem_we_s    = 1'b1;
               mem_waddr_s = clr_cnt_q;
               mem_wdata_s = '0;
            end
            RUN:     mem_we_s = wb_hit_s;
            default: mem_we_s = 1'b0;
         endcase
      end
   end

   // Storage has no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         regs_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Source operand 1: zero while clearing or for x0, optional same-cycle forwarding.
   always_comb begin
      rs1_data_s = '0;
      if ((state_q != RUN) || (rs1_id_i == '0)) begin
         rs1_data_s = '0;
      end else if ((BYPASS != 0) && wb_hit_s && (wb_rd_id_i == rs1_id_i)) begin
         rs1_data_s = wb_rd_write_data_i;
      end else begin
         rs1_data_s = regs_q[rs1_id_i];
      end
   end

   // Source operand 2: same policy as operand 1.
   always_comb begin
      rs2_data_s = '0;
      if ((state_q != RUN) || (rs2_id_i == '0)) begin
         rs2_data_s = '0;
      end else if ((BYPASS != 0) && wb_hit_s && (wb_rd_id_i == rs2_id_i)) begin
         rs2_data_s = wb_rd_write_data_i;
      end else begin
         rs2_data_s = regs_q[rs2_id_i];
      end
   end

   // Clear/run sequencer with its registered status and debug outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= ADDR_W'(1);
         rf_ready_q <= 1'b0;
         wb_drop_q  <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               dbg_data_q <= '0;
               if (wb_hit_s) begin
                  wb_drop_q <= 1'b1;
               end
               if (clr_cnt_q == ADDR_W'(REG_NUM - 1)) begin
                  state_q    <= RUN;
                  rf_ready_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               end
            end
            RUN: begin
               // Debug sees the pre-edge contents; no forwarding here.
               dbg_data_q <= (dbg_id_i == '0) ? '0 : regs_q[dbg_id_i];
            end
            default: begin
               state_q    <= CLEAR;
               clr_cnt_q  <= ADDR_W'(1);
               rf_ready_q <= 1'b0;
               dbg_data_q <= '0;
            end
         endcase
      end
   end

   assign rs1_data_o = rs1_data_s;
   assign rs2_data_o = rs2_data_s;
   assign dbg_data_o = dbg_data_q;
   assign rf_ready_o = rf_ready_q;
   assign wb_drop_o  = wb_drop_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: one instance with forwarding, one without,
// driven by shared stimulus; expectations go through a scoreboard queue.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_id, rs1_id, rs2_id, dbg_id;
   logic [31:0] wb_data;
   logic [31:0] rs1_b, rs2_b, dbg_b, rs1_n, rs2_n, dbg_n;
   logic        rdy_b, drop_b, rdy_n, drop_n;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(32), .REG_NUM(32), .ADDR_W(5), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .wb_rd_write_en_i(wb_en), .wb_rd_id_i(wb_id), .wb_rd_write_data_i(wb_data),
      .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
      .rs1_data_o(rs1_b), .rs2_data_o(rs2_b),
      .dbg_id_i(dbg_id), .dbg_data_o(dbg_b),
      .rf_ready_o(rdy_b), .wb_drop_o(drop_b)
   );

   wb_regfile #(.XLEN(32), .REG_NUM(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst),
      .wb_rd_write_en_i(wb_en), .wb_rd_id_i(wb_id), .wb_rd_write_data_i(wb_data),
      .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
      .rs1_data_o(rs1_n), .rs2_data_o(rs2_n),
      .dbg_id_i(dbg_id), .dbg_data_o(dbg_n),
      .rf_ready_o(rdy_n), .wb_drop_o(drop_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic wb_drive(input logic en, input logic [4:0] id, input logic [31:0] data);
      wb_en   = en;
      wb_id   = id;
      wb_data = data;
   endtask

   task automatic test_reset();
      exp_t e;
      int   cnt;
      rst = 1'b1;
      wb_drive(1'b0, 5'd0, 32'd0);
      rs1_id = 5'd0; rs2_id = 5'd0; dbg_id = 5'd0;
      tick(); tick();
      push("reset_rdy_low", 32'd0);
      push("reset_dbg", 32'd0);
      push("reset_drop", 32'd0);
      rst = 1'b0;
      e = sb_q.pop_front(); checks++;
      if ({31'd0, rdy_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rdy_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (dbg_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, dbg_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
      push("reset_clear_cycles", 32'd31);
      cnt = 0;
      while (!rdy_b && cnt < 40) begin
         tick();
         cnt++;
      end
      e = sb_q.pop_front(); checks++;
      if (cnt !== int'(e.exp)) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, cnt, e.exp); end
      push("reset_rdy_nb", 32'd1);
      e = sb_q.pop_front(); checks++;
      if ({31'd0, rdy_n} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rdy_n, e.exp); end
      for (int i = 1; i < 32; i++) begin
         rs1_id = 5'(i);
         push("reset_zero_rs1", 32'd0);
         #1;
         e = sb_q.pop_front(); checks++;
         if (rs1_b !== e.exp) begin failures++; $display("FAIL %s x%0d got=%h exp=%h", e.name, i, rs1_b, e.exp); end
      end
      push("reset_drop_after", 32'd0);
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
   endtask

   task automatic test_write_read();
      exp_t e;
      wb_drive(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      wb_drive(1'b0, 5'd0, 32'd0);
      rs1_id = 5'd5; rs2_id = 5'd5;
      push("wr_x5_rs1", 32'hDEADBEEF);
      push("wr_x5_rs2", 32'hDEADBEEF);
      push("wr_x5_rs1_nb", 32'hDEADBEEF);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs2_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs2_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs1_n !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_n, e.exp); end
      wb_drive(1'b1, 5'd0, 32'h12345678);
      rs1_id = 5'd0;
      push("x0_no_forward", 32'd0);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      tick();
      wb_drive(1'b0, 5'd0, 32'd0);
      dbg_id = 5'd0;
      push("x0_read", 32'd0);
      push("x0_no_drop", 32'd0);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
   endtask

   task automatic test_bypass();
      exp_t e;
      wb_drive(1'b1, 5'd7, 32'h11111111);
      tick();
      wb_drive(1'b1, 5'd7, 32'hA5A5A5A5);
      rs1_id = 5'd7; dbg_id = 5'd7;
      push("bypass_rs1", 32'hA5A5A5A5);
      push("nobypass_rs1", 32'h11111111);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs1_n !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_n, e.exp); end
      push("dbg_old_data", 32'h11111111);
      push("dbg_old_data_nb", 32'h11111111);
      tick();
      wb_drive(1'b0, 5'd0, 32'd0);
      e = sb_q.pop_front(); checks++;
      if (dbg_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, dbg_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (dbg_n !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, dbg_n, e.exp); end
      push("x7_stored_nb", 32'hA5A5A5A5);
      push("dbg_new_data", 32'hA5A5A5A5);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_n !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_n, e.exp); end
      tick();
      e = sb_q.pop_front(); checks++;
      if (dbg_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, dbg_b, e.exp); end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] prev;
      prev   = 32'd0;
      rs2_id = 5'd31;
      for (int k = 1; k <= 3; k++) begin
         wb_drive(1'b1, 5'd31, 32'(k));
         push("b2b_bypass", 32'(k));
         push("b2b_nobypass", prev);
         #1;
         e = sb_q.pop_front(); checks++;
         if (rs2_b !== e.exp) begin failures++; $display("FAIL %s k=%0d got=%h exp=%h", e.name, k, rs2_b, e.exp); end
         e = sb_q.pop_front(); checks++;
         if (rs2_n !== e.exp) begin failures++; $display("FAIL %s k=%0d got=%h exp=%h", e.name, k, rs2_n, e.exp); end
         prev = 32'(k);
         tick();
      end
      wb_drive(1'b0, 5'd0, 32'd0);
      push("b2b_final", 32'd3);
      push("b2b_final_nb", 32'd3);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs2_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs2_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs2_n !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs2_n, e.exp); end
   endtask

   task automatic test_clear_drop();
      exp_t e;
      int   cnt;
      wb_drive(1'b1, 5'd3, 32'h00000099);
      tick();
      wb_drive(1'b1, 5'd31, 32'h00000077);
      tick();
      wb_drive(1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (9) tick();
      wb_drive(1'b1, 5'd3, 32'h00000055);
      rs1_id = 5'd31; dbg_id = 5'd31;
      push("clear_rs1_forced0", 32'd0);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      push("clear_drop_set", 32'd1);
      push("clear_dbg_forced0", 32'd0);
      tick();
      wb_drive(1'b0, 5'd0, 32'd0);
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (dbg_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, dbg_b, e.exp); end
      cnt = 0;
      while (!rdy_b && cnt < 40) begin
         tick();
         cnt++;
      end
      push("clear_rdy_timeout", 32'd1);
      push("clear_drop_sticky", 32'd1);
      push("clear_x3_zero", 32'd0);
      push("clear_x31_zero", 32'd0);
      rs1_id = 5'd3; rs2_id = 5'd31;
      #1;
      e = sb_q.pop_front(); checks++;
      if ({31'd0, rdy_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rdy_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if (rs2_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs2_b, e.exp); end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int   cnt;
      for (int i = 1; i < 32; i++) begin
         wb_drive(1'b1, 5'(i), 32'(i));
         tick();
      end
      wb_drive(1'b0, 5'd0, 32'd0);
      rs1_id = 5'd17;
      push("fill_x17", 32'd17);
      #1;
      e = sb_q.pop_front(); checks++;
      if (rs1_b !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rs1_b, e.exp); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("midrst_rdy_low", 32'd0);
      push("midrst_drop_cleared", 32'd0);
      e = sb_q.pop_front(); checks++;
      if ({31'd0, rdy_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, rdy_b, e.exp); end
      e = sb_q.pop_front(); checks++;
      if ({31'd0, drop_b} !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, drop_b, e.exp); end
      push("midrst_clear_cycles", 32'd31);
      cnt = 0;
      while (!rdy_b && cnt < 40) begin
         tick();
         cnt++;
      end
      e = sb_q.pop_front(); checks++;
      if (cnt !== int'(e.exp)) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, cnt, e.exp); end
      for (int i = 1; i < 32; i++) begin
         rs2_id = 5'(i);
         dbg_id = 5'(i);
         push("midrst_rs2_zero", 32'd0);
         push("midrst_dbg_zero", 32'd0);
         #1;
         e = sb_q.pop_front(); checks++;
         if (rs2_b !== e.exp) begin failures++; $display("FAIL %s x%0d got=%h exp=%h", e.name, i, rs2_b, e.exp); end
         tick();
         e = sb_q.pop_front(); checks++;
         if (dbg_b !== e.exp) begin failures++; $display("FAIL %s x%0d got=%h exp=%h", e.name, i, dbg_b, e.exp); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_back_to_back();
      test_clear_drop();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
